// File: rtl/memram_arbiter_pkg.sv
// Shared constants for memram controllers: FSM state encoding and the
// round-robin pick used to choose between two requesters.
package memram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } memram_state_e;

    // Reset value of last_grant: requester 0 wins the first contention.
    localparam logic LAST_GRANT_RST = 1'b1;

    // Returns the id to grant; only meaningful when at least one valid is set.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) begin
            return ~last;
        end
        return v1;
    endfunction

endpackage

// File: rtl/memram_arbiter_memram.sv
// Single-port RAM: synchronous write, asynchronous read. Contents are never
// reset so data survives an arbiter reset.
module memram #(
    parameter int address_length = 6,
    parameter int data_length    = 8
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [address_length-1:0] addr,
    input  logic [data_length-1:0]    wdata,
    output logic [data_length-1:0]    rdata
);

    logic [data_length-1:0] mem [2**address_length];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/memram_arbiter.sv
// Two-requester round-robin arbiter in front of a single memram instance.
// Each accepted access runs IDLE -> ACCESS -> RESP; done pulses in RESP.
//
// state  | meaning
// IDLE   | waiting for a handshake; ready offered to the granted requester
// ACCESS | captured address drives the RAM; write strobed here only
// RESP   | done pulse to the granted requester; read data now registered
module memram_arbiter
    import memram_arbiter_pkg::*;
#(
    parameter int address_length = 6,
    parameter int data_length    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req0_valid,
    input  logic                      req0_wren,
    input  logic [address_length-1:0] req0_addr,
    input  logic [data_length-1:0]    req0_wdata,
    output logic                      req0_ready,
    output logic                      req0_done,
    output logic [data_length-1:0]    req0_rdata,
    input  logic                      req1_valid,
    input  logic                      req1_wren,
    input  logic [address_length-1:0] req1_addr,
    input  logic [data_length-1:0]    req1_wdata,
    output logic                      req1_ready,
    output logic                      req1_done,
    output logic [data_length-1:0]    req1_rdata,
    output logic                      busy
);

    memram_state_e             state_q, state_d;
    logic                      last_grant_q, last_grant_d;
    logic                      grant_q, grant_d;
    logic                      wren_q, wren_d;
    logic [address_length-1:0] addr_q, addr_d;
    logic [data_length-1:0]    wdata_q, wdata_d;
    logic [data_length-1:0]    rdata0_q, rdata0_d;
    logic [data_length-1:0]    rdata1_q, rdata1_d;

    logic                      grant_id;
    logic                      handshake;
    logic                      ram_we;
    logic [data_length-1:0]    ram_rdata;

    always_comb begin
        grant_id   = rr_pick(req0_valid, req1_valid, last_grant_q);
        req0_ready = (state_q == ST_IDLE) && req0_valid && !grant_id;
        req1_ready = (state_q == ST_IDLE) && req1_valid && grant_id;
        handshake  = req0_ready || req1_ready;

        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        wren_d       = wren_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    state_d      = ST_ACCESS;
                    grant_d      = grant_id;
                    last_grant_d = grant_id;
                    wren_d       = grant_id ? req1_wren  : req0_wren;
                    addr_d       = grant_id ? req1_addr  : req0_addr;
                    wdata_d      = grant_id ? req1_wdata : req0_wdata;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                if (!wren_q) begin
                    if (grant_q) begin
                        rdata1_d = ram_rdata;
                    end else begin
                        rdata0_d = ram_rdata;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LAST_GRANT_RST;
            grant_q      <= 1'b0;
            wren_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            wren_q       <= wren_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Reset forces state to IDLE asynchronously, which kills a pending write.
    assign ram_we     = wren_q && (state_q == ST_ACCESS);
    assign req0_done  = (state_q == ST_RESP) && !grant_q;
    assign req1_done  = (state_q == ST_RESP) && grant_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;
    assign busy       = (state_q != ST_IDLE);

    memram #(
        .address_length(address_length),
        .data_length   (data_length)
    ) u_memram (
        .clk  (clk),
        .we   (ram_we),
        .addr (addr_q),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_memram_arbiter.sv
// Scoreboard bench for memram_arbiter: directed scenarios plus random traffic
// from two requesters, checked against an array-based memory model.
module tb_memram_arbiter;

    typedef struct {
        int         id;
        bit         wr;
        logic [5:0] addr;
        logic [7:0] data;
        int         cyc;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v[2];
    logic       w[2];
    logic [5:0] a[2];
    logic [7:0] d[2];
    logic       rdy[2];
    logic       dn[2];
    logic [7:0] rd[2];
    logic       busy;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    txn_t       sbq[$];
    txn_t       t;
    int         grant_log[$];
    logic [7:0] mdl_mem[64];
    logic [7:0] mdl_rd[2];
    int         last_id = 1;
    int         wait_g[2];
    int         hs_cyc[2];
    logic [7:0] a0_init;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    memram_arbiter #(.address_length(6), .data_length(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(v[0]),
        .req0_wren (w[0]),
        .req0_addr (a[0]),
        .req0_wdata(d[0]),
        .req0_ready(rdy[0]),
        .req0_done (dn[0]),
        .req0_rdata(rd[0]),
        .req1_valid(v[1]),
        .req1_wren (w[1]),
        .req1_addr (a[1]),
        .req1_wdata(d[1]),
        .req1_ready(rdy[1]),
        .req1_done (dn[1]),
        .req1_rdata(rd[1]),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: logs handshakes into the scoreboard and retires them on done.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            mdl_rd[0] = 8'h00;
            mdl_rd[1] = 8'h00;
            last_id   = 1;
            wait_g[0] = 0;
            wait_g[1] = 0;
        end else begin
            if (rdy[0] || rdy[1]) begin
                chk("ready_onehot", 32'(rdy[0] & rdy[1]), 0);
                chk("ready_only_idle", 32'(busy), 0);
            end
            for (int i = 0; i < 2; i++) begin
                if (rdy[i]) chk("ready_needs_valid", 32'(v[i]), 1);
            end
            if (v[0] && v[1] && !busy) chk("round_robin", 32'(rdy[1-last_id]), 1);
            for (int i = 0; i < 2; i++) begin
                if (rdy[i] && v[i]) begin
                    sbq.push_back('{i, w[i], a[i], d[i], cyc});
                    chk("starvation", 32'(wait_g[i] <= 1), 1);
                    wait_g[i] = 0;
                    if (v[1-i]) wait_g[1-i]++;
                    last_id   = i;
                    hs_cyc[i] = cyc;
                    grant_log.push_back(i);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (!v[i]) wait_g[i] = 0;
            end
            if (dn[0] || dn[1]) begin
                chk("done_onehot", 32'(dn[0] & dn[1]), 0);
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=done0:%0b,done1:%0b required=no_done", dn[0], dn[1]);
                end else begin
                    t = sbq.pop_front();
                    chk("done_id", 32'(dn[t.id]), 1);
                    chk("done_latency", 32'(cyc - t.cyc), 2);
                    if (t.wr) mdl_mem[t.addr] = t.data;
                    else      mdl_rd[t.id]    = mdl_mem[t.addr];
                    chk("rdata_granted", 32'(rd[t.id]), 32'(mdl_rd[t.id]));
                    chk("rdata_other", 32'(rd[1-t.id]), 32'(mdl_rd[1-t.id]));
                end
            end
        end
    end

    task automatic issue(input int id, input bit wr_i, input logic [5:0] ad,
                         input logic [7:0] dt, input bit keep);
        int n;
        if (!v[id]) begin
            @(posedge clk);
            #1;
        end
        v[id] = 1'b1; w[id] = wr_i; a[id] = ad; d[id] = dt;
        n = 0;
        @(negedge clk);
        while (!rdy[id] && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!rdy[id]) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout id=%0d actual=no_ready required=ready", id);
            v[id] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (!keep) v[id] = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while ((busy || sbq.size() != 0) && n < 50) begin
            n++;
            @(negedge clk);
            #1;
        end
        if (busy || sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=busy:%0b,pending:%0d required=idle", busy, sbq.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        v[0] = 1'b0;
        v[1] = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", {30'd0, dn[1], dn[0]}, 0);
        chk("rst_rdata", {16'd0, rd[1], rd[0]}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_thread(input int id);
        bit kp;
        kp = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!kp) repeat ($urandom_range(0, 3)) @(posedge clk);
            kp = (k < 39) && ($urandom_range(0, 1) == 1);
            issue(id, $urandom_range(0, 1) == 1, 6'($urandom_range(0, 7)), 8'($urandom), kp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        v[0] = 1'b0; v[1] = 1'b0; w[0] = 1'b0; w[1] = 1'b0;
        a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0;
        wait_g[0] = 0; wait_g[1] = 0; hs_cyc[0] = 0; hs_cyc[1] = 0;
        mdl_rd[0] = 8'h00; mdl_rd[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy0", 32'(busy), 0);
        chk("rst_rdata0", {16'd0, rd[1], rd[0]}, 0);

        // Write right out of reset: ready same cycle, done two cycles later.
        v[0] = 1'b1; w[0] = 1'b1; a[0] = 6'd5; d[0] = 8'hA5;
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_ready0", 32'(rdy[0]), 1);
        @(posedge clk);
        #1;
        v[0] = 1'b0;
        @(negedge clk);
        chk("busy_access", 32'(busy), 1);
        chk("no_done_access", 32'(dn[0]), 0);
        @(negedge clk);
        chk("busy_resp", 32'(busy), 1);
        chk("done0_resp", 32'(dn[0]), 1);
        @(negedge clk);
        chk("busy_after", 32'(busy), 0);
        issue(0, 1'b0, 6'd5, 8'h00, 1'b0);
        wait_idle();
        chk("read_back_a5", 32'(rd[0]), 32'h0000_00A5);

        // Fill every address so later reads have known model values.
        for (int i = 0; i < 64; i++) begin
            logic [7:0] dat;
            dat = 8'($urandom);
            if (i == 0) a0_init = dat;
            issue(i % 2, 1'b1, 6'(i), dat, 1'b0);
        end
        wait_idle();

        // Simultaneous reads after reset: req0 first, req1 three cycles later.
        do_reset();
        fork
            issue(0, 1'b0, 6'd1, 8'h00, 1'b0);
            issue(1, 1'b0, 6'd2, 8'h00, 1'b0);
        join
        wait_idle();
        chk("contend_gap", 32'(hs_cyc[1] - hs_cyc[0]), 3);

        // Continuous contention alternates grants.
        grant_log.delete();
        fork
            for (int k = 0; k < 3; k++) issue(0, 1'b0, 6'($urandom_range(0, 63)), 8'h00, k < 2);
            for (int k = 0; k < 3; k++) issue(1, 1'b0, 6'($urandom_range(0, 63)), 8'h00, k < 2);
        join
        wait_idle();
        chk("alt_count", 32'(grant_log.size()), 6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++) chk("alt_order", 32'(grant_log[k]), 32'(k % 2));

        // Top address written by req1, read by req0; addr 0 untouched.
        issue(1, 1'b1, 6'd63, 8'h3C, 1'b0);
        issue(0, 1'b0, 6'd63, 8'h00, 1'b0);
        wait_idle();
        chk("addr63_rdata0", 32'(rd[0]), 32'h0000_003C);
        issue(0, 1'b0, 6'd0, 8'h00, 1'b0);
        wait_idle();
        chk("addr0_kept", 32'(rd[0]), 32'(a0_init));

        // Reset during the ACCESS cycle of a write suppresses it.
        issue(0, 1'b1, 6'd7, 8'h11, 1'b0);
        wait_idle();
        @(posedge clk);
        #1;
        v[0] = 1'b1; w[0] = 1'b1; a[0] = 6'd7; d[0] = 8'hFF;
        @(negedge clk);
        chk("abort_ready", 32'(rdy[0]), 1);
        @(posedge clk);
        #1;
        chk("abort_in_access", 32'(busy), 1);
        rst_n = 1'b0;
        v[0]  = 1'b0;
        #1;
        chk("abort_async_idle", 32'(busy), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_done", {30'd0, dn[1], dn[0]}, 0);
        end
        issue(0, 1'b0, 6'd7, 8'h00, 1'b0);
        wait_idle();
        chk("abort_addr7", 32'(rd[0]), 32'h0000_0011);

        // req1 pulses valid while busy and withdraws: no access for it.
        issue(0, 1'b0, 6'd9, 8'h00, 1'b0);
        v[1] = 1'b1; w[1] = 1'b1; a[1] = 6'd9; d[1] = 8'hEE;
        @(negedge clk);
        chk("drop_no_ready1", 32'(rdy[1]), 0);
        @(posedge clk);
        #1;
        v[1] = 1'b0;
        wait_idle();
        issue(0, 1'b0, 6'd9, 8'h00, 1'b0);
        wait_idle();
        chk("drop_ram_kept", 32'(rd[0]), 32'(mdl_mem[9]));

        // Random traffic from both requesters on a small address window.
        fork
            rand_thread(0);
            rand_thread(1);
        join
        wait_idle();
        chk("scoreboard_empty", 32'(sbq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
